// File: rtl/muldiv_sequencer_if.sv
// Execute stage <-> multiply/divide unit connection: request, operands,
// pipeline stall and the architectural HI/LO results.
interface muldiv_sequencer_if #(parameter int W = 32);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         read_req;
    logic         cancel;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in, read_req, cancel,
        input  busy, stall, done, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in, read_req, cancel,
        output busy, stall, done, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers. One bit per
// cycle on unsigned magnitudes, with the sign fixed up in a final cycle.
module muldiv_sequencer #(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic          is_div_q, is_div_d;
    logic          neg_res_q, neg_res_d;
    logic          neg_rem_q, neg_rem_d;
    logic          div_zero_q, div_zero_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  raw_a_q, raw_a_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          signed_op;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic          op_is_div;

    logic [W:0]    mul_sum;
    logic [W-1:0]  mul_acc;
    logic [W-1:0]  mul_work;
    logic [W:0]    rem_shift;
    logic          rem_ge;
    logic [W-1:0]  div_acc;
    logic [W-1:0]  div_work;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]  quot_fix;
    logic [W-1:0]  rem_fix;

    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        a_neg     = signed_op & bus.a_in[W-1];
        b_neg     = signed_op & bus.b_in[W-1];
        a_mag     = a_neg ? (-bus.a_in) : bus.a_in;
        b_mag     = b_neg ? (-bus.b_in) : bus.b_in;
    end

    // acc/work form one 2W-bit register: {product high, product low} for
    // multiply, {remainder, dividend-shifting-into-quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q} + {1'b0, opnd_q};
        if (work_q[0]) begin
            mul_acc  = mul_sum[W:1];
            mul_work = {mul_sum[0], work_q[W-1:1]};
        end else begin
            mul_acc  = {1'b0, acc_q[W-1:1]};
            mul_work = {acc_q[0], work_q[W-1:1]};
        end

        rem_shift = {acc_q, work_q[W-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        div_acc   = rem_ge ? (rem_shift[W-1:0] - opnd_q) : rem_shift[W-1:0];
        div_work  = {work_q[W-2:0], rem_ge};

        prod      = {acc_q, work_q};
        prod_fix  = neg_res_q ? (-prod) : prod;
        quot_fix  = neg_res_q ? (-work_q) : work_q;
        rem_fix   = neg_rem_q ? (-acc_q) : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        primed_d   = primed_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        work_d     = work_q;
        raw_a_d    = raw_a_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d    = CALC;
                            cnt_d      = CW'(W - 1);
                            primed_d   = 1'b0;
                            busy_d     = 1'b1;
                            is_div_d   = op_is_div;
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = (bus.op == OP_DIV) & a_neg;
                            div_zero_d = op_is_div && (bus.b_in == '0);
                            opnd_d     = op_is_div ? b_mag : a_mag;
                            work_d     = op_is_div ? a_mag : b_mag;
                            raw_a_d    = bus.a_in;
                        end
                        OP_MTHI: hi_d = bus.a_in;
                        OP_MTLO: lo_d = bus.a_in;
                        default: ;
                    endcase
                end
            end

            // The first CALC cycle only clears the accumulator; the W
            // iterations follow, so results land W+2 edges after the start.
            CALC: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (!primed_q) begin
                    primed_d = 1'b1;
                    acc_d    = '0;
                end else begin
                    acc_d  = is_div_q ? div_acc : mul_acc;
                    work_d = is_div_q ? div_work : mul_work;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (div_zero_q) begin
                        hi_d = raw_a_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            work_q     <= '0;
            raw_a_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            work_q     <= work_d;
            raw_a_q    <= raw_a_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Busy alone never stalls; only a muldiv request or HI/LO read does.
    assign bus.stall  = busy_q & (bus.start | bus.read_req);
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector table, multi-cycle corner sequences and random operations
// checked against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_sequencer;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.W(W)) bus ();

    muldiv_sequencer #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference model straight from the instruction definitions.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = '0;
        lo = '0;
        case (op)
            3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            3'd3: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin
                    q = sa / sb; r = sa % sb;
                    p = q; lo = p[31:0];
                    p = r; hi = p[31:0];
                end
            end
            3'd4: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin
                    uq = ua / ub; ur = ua % ub;
                    p = uq; lo = p[31:0];
                    p = ur; hi = p[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output int busy_gap);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        lat       = 0;
        busy_gap  = 0;
        while (lat < 60) begin
            if (!bus.busy) busy_gap++;
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
    endtask

    initial begin
        int          lat, gap, k, bad, dones;
        logic [31:0] ehi, elo;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        checks = 0;
        errors = 0;

        vecs[0] = '{"mult_neg3x5",   3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{"multu_max",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"div_neg7by2",   3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_7by0",     3'd4, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{"div_min_by_m1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{"multu_carry",   3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[6] = '{"divu_100by7",   3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[7] = '{"div_7byneg2",   3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{"div_neg8by0",   3'd3, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[9] = '{"mult_min_sq",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.read_req = 1'b0;
        bus.cancel   = 1'b0;
        #12;
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_done", bus.done, 0);
        check_output("reset_hilo", {bus.hi_out, bus.lo_out}, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] MTHI / reserved op / cancel in IDLE");
        start_op(3'd5, 32'h12345678, 32'd0);
        check_output("mthi_hi", bus.hi_out, 32'h12345678);
        check_output("mthi_busy", bus.busy, 0);
        @(posedge clk); #1;
        check_output("mthi_no_done", bus.done, 0);
        start_op(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_output("reserved_hilo", {bus.hi_out, bus.lo_out}, {32'h12345678, 32'h0});
        check_output("reserved_busy", bus.busy, 0);
        bus.cancel = 1'b1;
        start_op(3'd5, 32'hAAAAAAAA, 32'd0);
        check_output("cancel_idle_mthi", bus.hi_out, 32'h12345678);
        start_op(3'd1, 32'd3, 32'd3);
        check_output("cancel_idle_mult", bus.busy, 0);
        bus.cancel = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, gap);
            check_output({vecs[i].name, "_lat"}, lat, LAT);
            check_output({vecs[i].name, "_busy"}, gap, 0);
            check_output({vecs[i].name, "_hilo"}, {bus.hi_out, bus.lo_out}, {vecs[i].hi, vecs[i].lo});
        end

        $display("[TB] MFHI/MFLO stall while busy");
        start_op(3'd1, 32'hFFFFFFF9, 32'd6);
        k = 0; bad = 0;
        while (k < 60) begin
            @(posedge clk); k++; #1;
            if (k == 3) bus.read_req = 1'b1;
            #1;
            if (bus.stall !== ((k >= 3) && (k < LAT))) bad++;
            if (bus.done) break;
        end
        check_output("read_stall_pattern", bad, 0);
        check_output("read_stall_lat", k, LAT);
        @(posedge clk); #1;
        check_output("read_after_stall", bus.stall, 0);
        check_output("read_after_hilo", {bus.hi_out, bus.lo_out}, {32'hFFFFFFFF, 32'hFFFFFFD6});
        bus.read_req = 1'b0;

        $display("[TB] MTLO issued while busy");
        start_op(3'd1, 32'd2, 32'd3);
        k = 0; bad = 0;
        while (k < 60) begin
            @(posedge clk); k++; #1;
            if (k == 5) begin
                bus.start = 1'b1;
                bus.op    = 3'd6;
                bus.a_in  = 32'hDEADBEEF;
            end
            #1;
            if (bus.stall !== ((k >= 5) && (k < LAT))) bad++;
            if (bus.done) break;
        end
        check_output("mtlo_stall_pattern", bad, 0);
        check_output("mtlo_held_lo", {bus.hi_out, bus.lo_out}, {32'h0, 32'h6});
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        check_output("mtlo_reissued", {bus.hi_out, bus.lo_out}, {32'h0, 32'hDEADBEEF});
        check_output("mtlo_no_busy", bus.busy, 0);

        $display("[TB] cancel during DIV");
        start_op(3'd3, 32'd100, 32'd7);
        k = 0;
        while (k < 10) begin @(posedge clk); k++; #1; end
        check_output("cancel_busy_before", bus.busy, 1);
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check_output("cancel_busy_after", bus.busy, 0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check_output("cancel_no_done", dones, 0);
        check_output("cancel_hilo_kept", {bus.hi_out, bus.lo_out}, {32'h0, 32'hDEADBEEF});

        $display("[TB] async reset during DIV");
        start_op(3'd3, 32'd100, 32'd7);
        k = 0;
        while (k < 10) begin @(posedge clk); k++; #1; end
        reset = 1'b1;
        #1;
        check_output("areset_busy", bus.busy, 0);
        check_output("areset_done", bus.done, 0);
        check_output("areset_hilo", {bus.hi_out, bus.lo_out}, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            model(rop, ra, rb, ehi, elo);
            apply_stimulus(rop, ra, rb, lat, gap);
            check_output($sformatf("rand%0d_op%0d_lat", i, rop), lat, LAT);
            check_output($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb),
                         {bus.hi_out, bus.lo_out}, {ehi, elo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
